// File: rtl/fsm_spi_slave_rx.sv
// SPI slave receiver: oversamples sclk/cs/mosi with the system clock and
// deserialises DATA_W-bit words, flagging frames that cs aborts mid-word.
module fsm_spi_slave_rx #(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit SAMPLE_NEG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   shift_d;
  logic [DATA_W-1:0]   data_out_q;
  logic                data_valid_q;
  logic                busy_q;
  logic                frame_err_q;

  logic sclk_s1_q, sclk_s2_q, sclk_d_q;
  logic cs_s1_q, cs_s2_q, cs_d_q;
  logic mosi_s1_q, mosi_s2_q;

  logic sample_edge;
  logic cs_fall;
  logic cs_rise;
  logic last_bit;
  logic word_done;
  logic partial_abort;

  always_comb begin
    sample_edge = SAMPLE_NEG ? (sclk_d_q & ~sclk_s2_q) : (~sclk_d_q & sclk_s2_q);
    cs_fall     = cs_d_q & ~cs_s2_q;
    cs_rise     = ~cs_d_q & cs_s2_q;
    last_bit    = (bit_cnt_q == LAST_BIT);
    word_done   = sample_edge & last_bit;
    // A bit landing on the cs_rise cycle still counts towards a partial word.
    partial_abort = cs_rise & ~word_done & ((bit_cnt_q != '0) | sample_edge);
    if (MSB_FIRST) begin
      shift_d = {shift_q[DATA_W-2:0], mosi_s2_q};
    end else begin
      shift_d = {mosi_s2_q, shift_q[DATA_W-1:1]};
    end
  end

  // NOTE: state and outputs are registered with <= so every flop samples the
  // pre-edge values; reset clears the shift register too so no partial word survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s1_q    <= 1'b0;
      sclk_s2_q    <= 1'b0;
      sclk_d_q     <= 1'b0;
      cs_s1_q      <= 1'b0;
      cs_s2_q      <= 1'b0;
      cs_d_q       <= 1'b0;
      mosi_s1_q    <= 1'b0;
      mosi_s2_q    <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_s1_q    <= sclk;
      sclk_s2_q    <= sclk_s1_q;
      sclk_d_q     <= sclk_s2_q;
      cs_s1_q      <= cs;
      cs_s2_q      <= cs_s1_q;
      cs_d_q       <= cs_s2_q;
      mosi_s1_q    <= mosi;
      mosi_s2_q    <= mosi_s1_q;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (cs_fall) begin
            bit_cnt_q <= '0;
            state_q   <= RECV;
            busy_q    <= 1'b1;
          end
        end

        RECV: begin
          busy_q <= 1'b1;
          if (sample_edge) begin
            shift_q <= shift_d;
            if (last_bit) begin
              data_out_q   <= shift_d;
              data_valid_q <= 1'b1;
              bit_cnt_q    <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          if (cs_rise) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            bit_cnt_q   <= '0;
            frame_err_q <= partial_abort;
          end
        end

        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          bit_cnt_q <= '0;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fsm_spi_slave_rx.sv
// Directed bench for fsm_spi_slave_rx: an MSB-first and an LSB-first receiver
// share one SPI bus; expected words are queued as frames are sent.
module tb_fsm_spi_slave_rx;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic [7:0] do_m, do_l;
  logic       dv_m, dv_l;
  logic       busy_m, busy_l;
  logic       fe_m, fe_l;

  fsm_spi_slave_rx #(.DATA_W(8), .MSB_FIRST(1'b1), .SAMPLE_NEG(1'b1)) dut_m (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .data_out(do_m), .data_valid(dv_m), .busy(busy_m), .frame_err(fe_m)
  );

  fsm_spi_slave_rx #(.DATA_W(8), .MSB_FIRST(1'b0), .SAMPLE_NEG(1'b1)) dut_l (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .data_out(do_l), .data_valid(dv_l), .busy(busy_l), .frame_err(fe_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_m[$];
  logic [7:0] exp_l[$];
  int n_exp_valid = 0;
  int n_exp_err   = 0;
  int vcnt_m = 0, vcnt_l = 0;
  int ecnt_m = 0, ecnt_l = 0;
  int cyc = 0;
  int last_cyc = 0, prev_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard side: every valid pulse pops and compares one expected word.
  always @(negedge clk) begin
    if (rst) begin
      if (dv_m) begin
        vcnt_m++;
        prev_cyc = last_cyc;
        last_cyc = cyc;
        if (exp_m.size() > 0) check("data_out_msb", {24'd0, do_m}, {24'd0, exp_m.pop_front()});
      end
      if (dv_l) begin
        vcnt_l++;
        if (exp_l.size() > 0) check("data_out_lsb", {24'd0, do_l}, {24'd0, exp_l.pop_front()});
      end
      if (fe_m) ecnt_m++;
      if (fe_l) ecnt_l++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] b);
    exp_m.push_back(b);
    exp_l.push_back(rev8(b));
    n_exp_valid++;
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    wait_clk(4);
    sclk = 1'b0;
    wait_clk(4);
    sclk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    push_word(b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_valid_msb"}, vcnt_m, n_exp_valid);
    check({tag, "_valid_lsb"}, vcnt_l, n_exp_valid);
    check({tag, "_err_msb"}, ecnt_m, n_exp_err);
    check({tag, "_err_lsb"}, ecnt_l, n_exp_err);
    check({tag, "_queue_left"}, exp_m.size() + exp_l.size(), 0);
  endtask

  initial begin
    rst  = 1'b0;
    sclk = 1'b1;
    cs   = 1'b1;
    mosi = 1'b0;
    wait_clk(3);
    check("reset_outputs_msb", {21'd0, do_m, dv_m, busy_m, fe_m}, 32'd0);
    check("reset_outputs_lsb", {21'd0, do_l, dv_l, busy_l, fe_l}, 32'd0);
    rst = 1'b1;
    wait_clk(4);

    // 1: single frame 0xFE with latency and busy checks.
    cs_low();
    wait_clk(1);
    check("t1_busy_in_frame", {31'd0, busy_m}, 32'd1);
    push_word(8'hFE);
    for (int i = 7; i >= 1; i--) send_bit(1'b1);
    mosi = 1'b0;
    wait_clk(4);
    sclk = 1'b0;
    wait_clk(2);
    check("t1_latency_early", {31'd0, dv_m}, 32'd0);
    wait_clk(1);
    check("t1_latency_valid", {31'd0, dv_m}, 32'd1);
    wait_clk(1);
    check("t1_valid_one_cycle", {31'd0, dv_m}, 32'd0);
    sclk = 1'b1;
    wait_clk(2);
    check("t1_busy_before_cs_rise", {31'd0, busy_m}, 32'd1);
    cs_high();
    check("t1_busy_after_cs_rise", {30'd0, busy_m, busy_l}, 32'd0);
    check("t1_data_hold", {24'd0, do_m}, 32'h0000_00FE);
    check_counts("t1");

    // 2: two back-to-back words under one cs.
    cs_low();
    send_byte(8'hA5);
    send_byte(8'h3C);
    cs_high();
    check("t2_spacing", last_cyc - prev_cyc, 64);
    check("t2_final_msb", {24'd0, do_m}, 32'h0000_003C);
    check_counts("t2");

    // 3: abort after 5 bits keeps the last word.
    cs_low();
    send_byte(8'h12);
    cs_high();
    cs_low();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    n_exp_err++;
    cs_high();
    check("t3_hold_msb", {24'd0, do_m}, 32'h0000_0012);
    check("t3_hold_lsb", {24'd0, do_l}, 32'h0000_0048);
    check("t3_idle", {30'd0, busy_m, busy_l}, 32'd0);
    check_counts("t3");

    // 4: async reset in mid-frame clears everything immediately.
    cs_low();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("t4_busy_before_reset", {31'd0, busy_m}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t4_async_reset_msb", {21'd0, do_m, dv_m, busy_m, fe_m}, 32'd0);
    check("t4_async_reset_lsb", {21'd0, do_l, dv_l, busy_l, fe_l}, 32'd0);
    wait_clk(1);
    cs = 1'b1;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(4);
    cs_low();
    send_byte(8'h81);
    cs_high();
    check("t4_after_reset", {24'd0, do_m}, 32'h0000_0081);
    check_counts("t4");

    // 5: sclk activity with cs high is ignored.
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom_range(0, 1));
      wait_clk(4);
      sclk = ~sclk;
    end
    sclk = 1'b1;
    wait_clk(6);
    check("t5_idle_during_toggle", {30'd0, busy_m, busy_l}, 32'd0);
    check_counts("t5_toggle");
    cs_low();
    send_byte(8'h5A);
    cs_high();
    check("t5_frame", {24'd0, do_m}, 32'h0000_005A);
    check_counts("t5");

    // 6: bits 1,0,...,0 with cs rising on the last sample edge.
    cs_low();
    push_word(8'h80);
    send_bit(1'b1);
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    mosi = 1'b0;
    wait_clk(4);
    sclk = 1'b0;
    cs   = 1'b1;
    wait_clk(4);
    sclk = 1'b1;
    wait_clk(6);
    check("t6_lsb_first", {24'd0, do_l}, 32'h0000_0001);
    check("t6_msb_first", {24'd0, do_m}, 32'h0000_0080);
    check("t6_idle", {30'd0, busy_m, busy_l}, 32'd0);
    check_counts("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
